// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, buffers {inst, pc} in a 2-entry FIFO, handles redirects and fetch faults.
// Fetch-to-decode latency is 1 cycle; when the buffer is full and not popped, the PC holds and memory is re-read.

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2  // power of two so the pointers wrap naturally
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  assign head_dat = mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; the head is only observed while the count is non-zero.
  always_ff @(posedge i_clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(pop && empty));
  a_no_overflow:  assert property (@(posedge i_clk) disable iff (i_rst) !(push && full && !pop));
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_pc,
  input  logic [31:0] i_inst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_ready,
  output logic        o_fault,
  output logic [31:0] o_fault_pc
);
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [32:0] pc_inc;
  logic        seq_ok, redir_ok;
  logic        push, pop, empty, full;
  fetch_ent_t  push_ent, head_ent;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_PC);
  endfunction

  // The carry bit makes a PC+4 that wraps past 2^32 count as invalid.
  always_comb begin
    pc_inc   = {1'b0, pc_q} + 33'd4;
    seq_ok   = !pc_inc[32] && addr_ok(pc_inc[31:0]);
    redir_ok = addr_ok(i_redirect_pc);
    pop      = !empty && i_ready;
    push     = (state_q == RUN) && !i_redirect && (!full || pop);
    push_ent = '{inst: i_inst, pc: pc_q};
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_ent_t)),
    .DEPTH(2)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .flush    (i_redirect),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .empty    (empty),
    .full     (full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Redirect outranks push and fault entry; an invalid target faults without moving the PC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    if (i_redirect) begin
      if (redir_ok) begin
        state_d = RUN;
        pc_d    = i_redirect_pc;
      end else begin
        state_d    = FAULT;
        fault_pc_d = i_redirect_pc;
      end
    end else if (push) begin
      if (seq_ok) begin
        pc_d = pc_inc[31:0];
      end else begin
        state_d    = FAULT;
        fault_pc_d = pc_inc[31:0];
      end
    end
  end

  always_comb begin
    o_pc       = pc_q;
    o_valid    = !empty;
    o_inst     = o_valid ? head_ent.inst : '0;
    o_inst_pc  = o_valid ? head_ent.pc : '0;
    o_fault    = (state_q == FAULT) && empty;
    o_fault_pc = o_fault ? fault_pc_q : '0;
  end

  a_pc_valid: assert property (@(posedge i_clk) disable iff (i_rst) addr_ok(pc_q));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected PCs queued as stimulus is driven, checked at each decode handshake.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] o_pc;
  logic [31:0] i_inst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_ready;
  logic        o_fault;
  logic [31:0] o_fault_pc;

  int          total = 0;
  int          bad   = 0;
  int          hs    = 0;
  int          hs0;
  logic        mon_en = 1'b0;
  logic [31:0] sb [$];
  logic [31:0] mon_exp;

  fetch_unit #(.RESET_PC(RST_PC), .MEM_SIZE(1024)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_pc          (o_pc),
    .i_inst        (i_inst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_ready       (i_ready),
    .o_fault       (o_fault),
    .o_fault_pc    (o_fault_pc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign i_inst = memw(o_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] s);
    if (s[1:0] == 2'b00 && s <= 32'h3FC)
      for (logic [31:0] a = s; a <= 32'h3FC; a += 32'd4) sb.push_back(a);
  endtask

  task automatic redirect(input logic [31:0] t);
    i_redirect    = 1'b1;
    i_redirect_pc = t;
    cyc();
    i_redirect = 1'b0;
    sb.delete();
    push_seq(t);
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_valid && i_ready) begin
        hs++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_exp = sb.pop_front();
          chk("hs_pc", o_inst_pc, mon_exp);
          chk("hs_inst", o_inst, memw(mon_exp));
        end
      end else if (!o_valid) begin
        chk("idle_out", o_inst | o_inst_pc, 32'd0);
      end
      if (!o_fault) chk("fault_pc_idle", o_fault_pc, 32'd0);
    end
  end

  initial begin
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_pc", o_pc, RST_PC);
    chk("rst_vld", {31'd0, o_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    chk("rst_fault_pc", o_fault_pc, 32'd0);

    // streaming at full rate
    i_rst = 1'b0; push_seq(RST_PC); mon_en = 1'b1;
    cyc();
    chk("first_vld", {31'd0, o_valid}, 32'd1);
    chk("first_pc", o_inst_pc, RST_PC);
    chk("pc_adv", o_pc, RST_PC + 32'd4);
    hs0 = hs;
    for (int i = 2; i < 10; i++) begin
      cyc();
      chk("stream_vld", {31'd0, o_valid}, 32'd1);
      chk("stream_pc", o_pc, RST_PC + 32'(4 * i));
    end
    chk("no_gaps", 32'(hs - hs0), 32'd8);

    // backpressure after a fresh reset
    mon_en = 1'b0; i_rst = 1'b1;
    cyc();
    i_rst = 1'b0; i_ready = 1'b0; sb.delete(); push_seq(RST_PC); mon_en = 1'b1;
    repeat (5) cyc();
    chk("bp_pc", o_pc, RST_PC + 32'd8);
    chk("bp_head", o_inst_pc, RST_PC);
    chk("bp_vld", {31'd0, o_valid}, 32'd1);
    i_ready = 1'b1; hs0 = hs;
    repeat (4) cyc();
    chk("bp_drain", 32'(hs - hs0), 32'd4);

    // redirect with a full buffer
    i_ready = 1'b0;
    repeat (3) cyc();
    i_ready = 1'b1;
    redirect(32'h40);
    chk("rd_vld", {31'd0, o_valid}, 32'd0);
    chk("rd_pc", o_pc, 32'h40);
    cyc();
    chk("rd_head", o_inst_pc, 32'h40);
    repeat (3) cyc();

    // misaligned redirect faults, valid redirect recovers
    redirect(32'h42);
    chk("mis_fault", {31'd0, o_fault}, 32'd1);
    chk("mis_fault_pc", o_fault_pc, 32'h42);
    chk("mis_pc_hold", o_pc, 32'h50);
    repeat (2) cyc();
    chk("mis_fault_hold", {31'd0, o_fault}, 32'd1);
    redirect(32'h10);
    chk("rec_fault", {31'd0, o_fault}, 32'd0);
    chk("rec_pc", o_pc, 32'h10);
    cyc();
    chk("rec_head", o_inst_pc, 32'h10);
    repeat (2) cyc();
    redirect(32'hFFFF_FFFC);
    chk("oor_fault_pc", o_fault_pc, 32'hFFFF_FFFC);

    // sequential run off the end of memory
    redirect(32'h3F8);
    chk("end_pc0", o_pc, 32'h3F8);
    chk("end_nofault0", {31'd0, o_fault}, 32'd0);
    cyc();
    chk("end_head0", o_inst_pc, 32'h3F8);
    chk("end_pc1", o_pc, 32'h3FC);
    cyc();
    chk("end_head1", o_inst_pc, 32'h3FC);
    chk("end_fault_wait", {31'd0, o_fault}, 32'd0);
    cyc();
    chk("end_fault", {31'd0, o_fault}, 32'd1);
    chk("end_fault_pc", o_fault_pc, 32'h400);
    chk("end_vld", {31'd0, o_valid}, 32'd0);
    chk("end_pc_hold", o_pc, 32'h3FC);
    chk("end_sb_drained", 32'(sb.size()), 32'd0);

    // reset beats a simultaneous redirect with a non-empty buffer
    i_ready = 1'b0;
    redirect(32'h20);
    repeat (2) cyc();
    chk("pre_rst_vld", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h81;
    cyc();
    i_rst = 1'b0; i_redirect = 1'b0;
    chk("rr_pc", o_pc, RST_PC);
    chk("rr_vld", {31'd0, o_valid}, 32'd0);
    chk("rr_fault", {31'd0, o_fault}, 32'd0);
    sb.delete(); push_seq(RST_PC); i_ready = 1'b1;
    repeat (4) cyc();
    chk("rr_resume", o_pc, RST_PC + 32'd16);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
